// File: rtl/fetch_unit_pkg.sv
// Shared rv32i fetch definitions: data width, reset PC,
// PC step and the fetch FSM state encodings.
package fetch_unit_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_INC           = 32'd4;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch with a one-entry slot,
// branch redirect and discard of in-flight responses.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            branch_ld,
    input  logic [XLEN-1:0] branch_target,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready,
    output logic            misaligned
);

    fetch_state_t    state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic [XLEN-1:0] req_addr, req_addr_n;
    logic            valid_n;
    logic [XLEN-1:0] data_n, ipc_n;
    logic            mis_n;
    logic [XLEN-1:0] tgt;

    assign tgt       = {branch_target[XLEN-1:2], 2'b00};
    assign imem_req  = !rst && (state != S_HOLD);
    assign imem_addr = req_addr;

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        req_addr_n = req_addr;
        valid_n    = inst_valid;
        data_n     = inst_data;
        ipc_n      = inst_pc;
        mis_n      = branch_ld && (branch_target[1:0] != 2'b00);
        if (branch_ld) begin
            pc_n    = tgt;
            valid_n = 1'b0;
            // an in-flight request must still complete before re-issuing
            unique case (state)
                S_HOLD: begin
                    state_n    = S_REQ;
                    req_addr_n = tgt;
                end
                S_REQ, S_DROP: begin
                    if (imem_ack) begin
                        state_n    = S_REQ;
                        req_addr_n = tgt;
                    end else begin
                        state_n = S_DROP;
                    end
                end
                default: state_n = S_REQ;
            endcase
        end else begin
            unique case (state)
                S_REQ: begin
                    if (imem_ack) begin
                        data_n  = imem_rdata;
                        ipc_n   = req_addr;
                        valid_n = 1'b1;
                        pc_n    = pc + PC_INC;
                        state_n = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (inst_valid && inst_ready) begin
                        valid_n    = 1'b0;
                        state_n    = S_REQ;
                        req_addr_n = pc;
                    end
                end
                S_DROP: begin
                    if (imem_ack) begin
                        state_n    = S_REQ;
                        req_addr_n = pc;
                    end
                end
                default: state_n = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            req_addr   <= RESET_PC;
            inst_valid <= 1'b0;
            inst_data  <= '0;
            inst_pc    <= '0;
            misaligned <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            req_addr   <= req_addr_n;
            inst_valid <= valid_n;
            inst_data  <= data_n;
            inst_pc    <= ipc_n;
            misaligned <= mis_n;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Random and directed stimulus for fetch_unit, checked against a
// program-order model of the delivered instruction stream.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        branch_ld;
    logic [31:0] branch_target;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        misaligned;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .branch_ld     (branch_ld),
        .branch_target (branch_target),
        .inst_valid    (inst_valid),
        .inst_data     (inst_data),
        .inst_pc       (inst_pc),
        .inst_ready    (inst_ready),
        .misaligned    (misaligned)
    );

    int total = 0;
    int bad   = 0;

    // memory responder state
    bit          out_pend  = 1'b0;
    logic [31:0] out_addr  = '0;
    int          wcnt      = 0;
    int          cur_lat   = 0;
    int          fixed_lat = 0;
    bit          rand_lat  = 1'b0;
    bit          force_ack = 1'b0;

    // reference model: next program-order PC decode should see
    logic [31:0] exp_pc  = RST_PC;
    logic        exp_mis = 1'b0;
    int          cyc        = 0;
    int          last_acc   = -1;
    int          deliveries = 0;
    bit          tput_on    = 1'b0;
    bit          saw_zero   = 1'b0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input logic r, input logic bl,
                        input logic [31:0] bt, input logic rdy);
        logic        acc;
        logic        held_v;
        logic [31:0] held_d;
        logic [31:0] held_p;
        rst           = r;
        branch_ld     = bl;
        branch_target = bt;
        inst_ready    = rdy;
        imem_ack      = 1'b0;
        imem_rdata    = 32'hDEAD_BEEF;
        #1;
        if (!r) begin
            if (out_pend) begin
                chk("req_held", 32'(imem_req), 1);
                chk("addr_held", imem_addr, out_addr);
            end else if (imem_req) begin
                chk("issue_addr", imem_addr, exp_pc);
                out_pend = 1'b1;
                out_addr = imem_addr;
                wcnt     = 0;
                cur_lat  = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
            end
            if (inst_valid) chk("hold_noreq", 32'(imem_req), 0);
            if (imem_req && out_pend && wcnt == cur_lat) begin
                imem_ack   = 1'b1;
                imem_rdata = mem(out_addr);
            end
        end
        if (force_ack) imem_ack = 1'b1;
        acc    = 1'b0;
        held_v = inst_valid;
        held_d = inst_data;
        held_p = inst_pc;
        if (r) begin
            exp_pc   = RST_PC;
            exp_mis  = 1'b0;
            out_pend = 1'b0;
        end else begin
            if (imem_req && imem_ack) out_pend = 1'b0;
            else if (out_pend) wcnt++;
            if (bl) begin
                exp_pc  = {bt[31:2], 2'b00};
                exp_mis = (bt[1:0] != 2'b00);
            end else begin
                exp_mis = 1'b0;
                if (inst_valid && rdy) begin
                    acc = 1'b1;
                    chk("slot_pc", inst_pc, exp_pc);
                    chk("slot_data", inst_data, mem(exp_pc));
                    if (tput_on && last_acc >= 0)
                        chk("tput", 32'(cyc - last_acc), 2);
                    last_acc = cyc;
                    if (inst_pc == 32'h0) saw_zero = 1'b1;
                    exp_pc = exp_pc + 32'd4;
                    deliveries++;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("misaligned", 32'(misaligned), 32'(exp_mis));
        if (r) begin
            chk("rst_valid", 32'(inst_valid), 0);
            chk("rst_req", 32'(imem_req), 0);
            chk("rst_data", inst_data, 0);
            chk("rst_pc", inst_pc, 0);
        end else if (bl) begin
            chk("redir_clr", 32'(inst_valid), 0);
        end else if (held_v && !acc) begin
            chk("hold_v", 32'(inst_valid), 1);
            chk("hold_d", inst_data, held_d);
            chk("hold_p", inst_pc, held_p);
        end
    endtask

    task automatic run(input int n, input logic rdy);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 32'h0, rdy);
    endtask

    task automatic to_full(input string tag);
        for (int i = 0; i < 40 && !inst_valid; i++)
            tick(1'b0, 1'b0, 32'h0, 1'b0);
        chk(tag, 32'(inst_valid), 1);
    endtask

    task automatic to_pending(input string tag);
        for (int i = 0; i < 40 && !out_pend; i++)
            tick(1'b0, 1'b0, 32'h0, 1'b1);
        chk(tag, 32'(out_pend), 1);
    endtask

    initial begin
        rst = 1'b1; branch_ld = 1'b0; branch_target = '0;
        inst_ready = 1'b0; imem_ack = 1'b0; imem_rdata = '0;

        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 32'h0, 1'b0);

        // back-to-back stream from reset: 0x100, 0x104, 0x108 ...
        fixed_lat = 0;
        tput_on   = 1'b1;
        last_acc  = -1;
        run(8, 1'b1);
        tput_on = 1'b0;
        chk("stream_cnt", 32'(deliveries >= 3), 1);

        // decode stalls on a full slot
        to_full("full_a");
        run(5, 1'b0);
        run(4, 1'b1);

        // redirect while a slow request is outstanding
        fixed_lat = 3;
        to_pending("pend_a");
        tick(1'b0, 1'b1, 32'h0000_0200, 1'b1);
        run(10, 1'b1);

        // misaligned redirect from a full slot
        fixed_lat = 0;
        to_full("full_b");
        tick(1'b0, 1'b1, 32'h0000_0202, 1'b0);
        run(6, 1'b1);

        // PC wrap at the top of the address space
        tick(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
        run(10, 1'b1);
        chk("wrap_seen", 32'(saw_zero), 1);

        // stray ack while the slot is full
        to_full("full_c");
        force_ack = 1'b1;
        tick(1'b0, 1'b0, 32'h0, 1'b0);
        force_ack = 1'b0;
        run(6, 1'b1);

        // reset with a request in flight and acks during reset
        fixed_lat = 3;
        to_pending("pend_b");
        force_ack = 1'b1;
        tick(1'b1, 1'b0, 32'h0, 1'b1);
        tick(1'b1, 1'b0, 32'h0, 1'b1);
        force_ack = 1'b0;
        tick(1'b1, 1'b0, 32'h0, 1'b1);
        run(12, 1'b1);

        // random traffic
        rand_lat = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            logic        r;
            logic        bl;
            logic [31:0] bt;
            logic        rdy;
            r   = ($urandom_range(0, 199) == 0);
            bl  = !r && ($urandom_range(0, 19) == 0);
            bt  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 | ($urandom & 32'hF)
                                             : $urandom;
            rdy = ($urandom_range(0, 9) < 7);
            tick(r, bl, bt, rdy);
        end
        chk("progress", 32'(deliveries > 200), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
